// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter in front of a shared 8:1 x DATA_W operand mux.
// Registers the winner's word and hands it downstream over valid/ready, acking the winner.
module mux8_rr_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          req,
  input  logic [8*DATA_W-1:0] in_data,
  output logic [2:0]          mux_sel,
  output logic [7:0]          grant,
  output logic [7:0]          ack,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic                out_ready
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [7:0]          grant_q, grant_d;
  logic [2:0]          mux_sel_q, mux_sel_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [2:0]          ptr_q, ptr_d;

  logic [DATA_W-1:0]   word [8];
  logic                xfer;
  logic [2:0]          next_ptr;
  logic [3:0]          idle_pick;
  logic [3:0]          xfer_pick;
  logic                load;
  logic [2:0]          load_sel;

  for (genvar gi = 0; gi < 8; gi++) begin : g_word
    assign word[gi] = in_data[DATA_W*gi +: DATA_W];
  end

  // Returns {found, index}; scanning offsets high to low lets the nearest one to start win.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = start + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    xfer      = (state_q == BUSY) && out_ready;
    next_ptr  = mux_sel_q + 3'd1;
    idle_pick = rr_pick(req, ptr_q);
    // The granted requester's req during its ack cycle belongs to the finishing transfer.
    xfer_pick = rr_pick(req & ~grant_q, next_ptr);

    state_d     = state_q;
    grant_d     = grant_q;
    mux_sel_d   = mux_sel_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ptr_d       = ptr_q;
    load        = 1'b0;
    load_sel    = '0;

    case (state_q)
      IDLE: begin
        if (idle_pick[3]) begin
          load     = 1'b1;
          load_sel = idle_pick[2:0];
        end
      end
      BUSY: begin
        if (out_ready) begin
          ptr_d = next_ptr;
          if (xfer_pick[3]) begin
            load     = 1'b1;
            load_sel = xfer_pick[2:0];
          end else begin
            state_d     = IDLE;
            grant_d     = '0;
            out_valid_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d     = BUSY;
      grant_d     = 8'd1 << load_sel;
      mux_sel_d   = load_sel;
      out_data_d  = word[load_sel];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      mux_sel_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      mux_sel_q   <= mux_sel_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ptr_q       <= ptr_d;
    end
  end

  assign ack       = xfer ? grant_q : 8'd0;
  assign grant     = grant_q;
  assign mux_sel   = mux_sel_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter sharing one 32-bit 8:1 operand path between eight requesters.
- Selects one requester, drives the 3-bit mux select, and registers that requester's word into an output buffer.
- Presents the word downstream with a valid/ready handshake and returns a one-cycle ack to the served requester.
- Sits in front of the shared mux8x1_32bit datapath in MiniMIPS.

Parameters:
- DATA_W, 32, width of each requester word and of out_data.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- req  input  8  level request per requester; bit i belongs to requester i.
- in_data  input  8*DATA_W  packed requester words; requester i at bits [DATA_W*i+DATA_W-1 : DATA_W*i].
- mux_sel  output  3  index of the currently or most recently granted requester.
- grant  output  8  one-hot grant, registered.
- ack  output  8  one-hot, one-cycle pulse when the granted word is accepted downstream.
- out_valid  output  1  out_data holds a word awaiting acceptance.
- out_data  output  DATA_W  registered word of the granted requester.
- out_ready  input  1  downstream can accept out_data this cycle.

Behaviour:
- One clock and one reset. Reset is synchronous and active-low: rst_n is sampled on the rising edge of clk.
- Reset values: state=IDLE, grant=0, ack=0, mux_sel=0, out_valid=0, out_data=0, priority pointer ptr=0 (requester 0 highest priority).
- Reset asserted in any state, including mid-transfer, forces all reset values on the next edge. The pending word is dropped and no ack is issued.
- Arbitration (combinational): search eligible req bits starting at index ptr, ascending with wrap 7->0. The first set bit wins.
- State IDLE:
  - If any req bit is set at the edge, register the winner w: grant=onehot(w), mux_sel=w, out_data=in_data[w], out_valid=1, go to BUSY.
  - Otherwise remain in IDLE.
  - Latency from req rising to out_valid is 1 cycle.
- State BUSY:
  - out_valid=1. grant, mux_sel and out_data are held stable.
  - A requester must hold req and its word until it sees ack.
  - If out_ready=0, remain in BUSY with no change. There is no timeout.
  - If out_ready=1 (transfer), ack[w] is asserted combinationally in that cycle: ack = grant when BUSY and out_ready.
  - On the transfer edge, ptr is set to (w+1) mod 8.
- Back-to-back operation, evaluated on the transfer edge:
  - Arbitrate over req with bit w masked. req[w] in the ack cycle belongs to the transaction being completed.
  - If a winner exists, load it directly and stay in BUSY. This gives zero bubble: one word per cycle while out_ready=1.
  - If no winner exists, clear grant and out_valid and go to IDLE. mux_sel and out_data keep their last values.
- If req[w] is still high in the cycle after ack, it is treated as a new request at lowest priority.
- A requester dropping req while granted is a protocol violation. The arbiter ignores it and keeps the grant until the transfer.
- Fairness: with all eight requesting continuously, grants rotate 0,1,...,7,0. Maximum wait is 7 transfers.
- ack and grant are always one-hot or zero. ack is never asserted outside BUSY.
- Width rule: out_data is exactly DATA_W, taken from the selected slice with no extension or truncation.

Test Plan:
- Reset then single request: rst_n=0 for 2 cycles, then req=8'b0000_0100 with word2=32'hDDDDDDDD and out_ready=1. Next cycle: out_valid=1, mux_sel=3'd2, grant=8'h04, out_data=32'hDDDDDDDD, ack=8'h04. Following cycle: IDLE, ptr=3.
- Round robin: words FFFFFFFF, EEEEEEEE, ..., 88888888 for requesters 0..7, req=8'hFF held, out_ready=1. mux_sel sequence is 0,1,...,7,0 on consecutive cycles, out_data tracks the words, no bubbles.
- Backpressure: req=8'h01, out_ready=0 for 5 cycles, then 1. out_valid, grant=8'h01 and out_data=32'hFFFFFFFF stay stable for all 5 cycles. Exactly one ack=8'h01 occurs, in the out_ready=1 cycle.
- Pointer wrap and masking: ptr=7 after serving 6, then req=8'h81. Requester 7 is granted first, then 0. With req[7] held through the ack cycle, the next grant is 0, not 7.
- Reset mid-operation: BUSY with mux_sel=5, out_ready=0, then rst_n=0 for one edge. Next cycle: out_valid=0, grant=0, ack=0, mux_sel=0, out_data=0, ptr=0, no ack ever issued for 5.
- Idle gap: req=0 after the last transfer. Within 1 cycle out_valid=0 and grant=0, mux_sel holds its last value, and the next req=8'h10 yields out_valid after 1 cycle.
